quad_step_decoder: RTL

- Upstream stage of counter_8bit. Converts an asynchronous two-phase quadrature encoder input (A/B) into the counter's `en` and `up_down` controls.
- Synchronises and glitch-filters each channel, then decodes Gray-code phase transitions into single-cycle step pulses with direction.
- Detects and counts illegal (double-bit) transitions.
- Connection: step_en drives counter_8bit.en; step_up drives counter_8bit.up_down.

---
 rtl/quad_pkg.sv | 26 ++
 rtl/quad_step_decoder_if.sv | 24 ++
 rtl/quad_glitch_filter.sv | 62 ++++++
 rtl/quad_step_decoder.sv | 111 +++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature step decoder: FSM states, phase encoding
// and the forward Gray-code successor.
package quad_pkg;

  typedef enum logic [0:0] {StInit, StTrack} state_e;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_00 = 2'b00;
  localparam phase_t PH_01 = 2'b01;
  localparam phase_t PH_11 = 2'b11;
  localparam phase_t PH_10 = 2'b10;

  // Forward rotation is 00 -> 01 -> 11 -> 10 -> 00.
  function automatic phase_t next_fwd(input phase_t ph);
    phase_t nxt;
    unique case (ph)
      PH_00:   nxt = PH_01;
      PH_01:   nxt = PH_11;
      PH_11:   nxt = PH_10;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_step_decoder_if.sv
// Encoder inputs, decoder controls and step/error outputs of the quadrature decoder.
interface quad_step_decoder_if #(
  parameter int unsigned ERR_W = 8
) ();
  logic             enc_a;
  logic             enc_b;
  logic             dec_en;
  logic             clr_err;
  logic             ready;
  logic             step_en;
  logic             step_up;
  logic             err;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output enc_a, enc_b, dec_en, clr_err,
    input  ready, step_en, step_up, err, err_cnt
  );

  modport slave (
    input  enc_a, enc_b, dec_en, clr_err,
    output ready, step_en, step_up, err, err_cnt
  );
endinterface

// File: rtl/quad_glitch_filter.sv
// Synchroniser plus run-length stability filter for one encoder channel; the filtered
// level follows the sample only after FILT_LEN identical consecutive samples.
module quad_glitch_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic level_next_o,
  output logic settled_o
);
  localparam int unsigned CntW = $clog2(FILT_LEN + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(FILT_LEN);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] vld_q, vld_d;
  logic                   last_q, last_d;
  logic [CntW-1:0]        run_q, run_d;
  logic                   level_q, level_d;
  logic                   smp, smp_vld;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], raw_i};
    // Samples are ignored until the synchroniser has been refilled after reset.
    vld_d   = {vld_q[SYNC_STAGES-2:0], 1'b1};
    smp     = sync_q[SYNC_STAGES-1];
    smp_vld = vld_q[SYNC_STAGES-1];
    last_d  = smp;
    run_d   = run_q;
    if (!smp_vld) begin
      run_d = '0;
    end else if (smp != last_q) begin
      run_d = CntW'(1);
    end else if (run_q != CntMax) begin
      run_d = run_q + 1'b1;
    end
    level_d = (run_d == CntMax) ? smp : level_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      vld_q   <= '0;
      last_q  <= 1'b0;
      run_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      run_q   <= run_d;
      level_q <= level_d;
    end
  end

  assign level_o      = level_q;
  assign level_next_o = level_d;
  assign settled_o    = (run_d == CntMax);

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature decoder: filters A/B, decodes Gray-code phase steps into registered step
// pulses with direction, and flags/counts double-bit (illegal) transitions.
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned ERR_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  quad_step_decoder_if.slave  bus_io
);
  logic       lvl_a, lvl_b, lvl_a_nxt, lvl_b_nxt, settled_a, settled_b;
  phase_t     phase, phase_nxt, moved;
  state_e     state_q, state_d;
  phase_t     prev_q, prev_d;
  logic       step_en_q, step_en_d;
  logic       step_up_q, step_up_d;
  logic       err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  quad_glitch_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_filt_a (
    .clk_i       (clk),
    .rst_i       (rst),
    .raw_i       (bus_io.enc_a),
    .level_o     (lvl_a),
    .level_next_o(lvl_a_nxt),
    .settled_o   (settled_a)
  );

  quad_glitch_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_filt_b (
    .clk_i       (clk),
    .rst_i       (rst),
    .raw_i       (bus_io.enc_b),
    .level_o     (lvl_b),
    .level_next_o(lvl_b_nxt),
    .settled_o   (settled_b)
  );

  assign phase     = {lvl_a, lvl_b};
  assign phase_nxt = {lvl_a_nxt, lvl_b_nxt};
  assign moved     = phase ^ prev_q;

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    step_en_d = 1'b0;
    step_up_d = step_up_q;
    err_d     = 1'b0;
    unique case (state_q)
      StInit: begin
        // Capture the level being committed this cycle so TRACK starts without a step.
        if (settled_a && settled_b) begin
          state_d = StTrack;
          prev_d  = phase_nxt;
        end
      end
      StTrack: begin
        prev_d = phase;
        if (moved == 2'b11) begin
          err_d = 1'b1;
        end else if (moved != 2'b00) begin
          step_en_d = bus_io.dec_en;
          if (bus_io.dec_en) begin
            step_up_d = (phase == next_fwd(prev_q));
          end
        end
      end
      default: state_d = StInit;
    endcase

    err_cnt_d = err_cnt_q;
    if (bus_io.clr_err) begin
      err_cnt_d = ERR_W'(err_d);
    end else if (err_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StInit;
      prev_q    <= PH_00;
      step_en_q <= 1'b0;
      step_up_q <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      step_en_q <= step_en_d;
      step_up_q <= step_up_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus_io.ready   = (state_q == StTrack);
  assign bus_io.step_en = step_en_q;
  assign bus_io.step_up = step_up_q;
  assign bus_io.err     = err_q;
  assign bus_io.err_cnt = err_cnt_q;

endmodule
